prf_write_arbiter: RTL and testbench

Parametrised, buffered successor to the 6-to-2 physical-regfile write compressor. It sits between N writeback sources (ALUs, LSU, MDU, CSR) and the M physical-regfile write ports. Each source channel has a one-entry pending buffer with a valid/ready handshake. Pending entries are granted to write ports round-robin, so no channel starves under sustained load. A flush drops all un-retired writebacks.

---
 rtl/prf_write_arbiter.sv | 126 ++++++++++++
 tb/tb_prf_write_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prf_write_arbiter.sv
// Buffered N-to-M physical regfile write arbiter: one pending entry per writeback
// channel, granted to the write ports round-robin starting at rr_ptr.
module prf_write_arbiter #(
  parameter int unsigned N_CH   = 6,
  parameter int unsigned N_PORT = 2,
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned CNT_W  = $clog2(N_CH + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic [N_CH-1:0]          wr_valid_i,
  input  logic [N_CH*ADDR_W-1:0]   wr_addr_i,
  input  logic [N_CH*DATA_W-1:0]   wr_data_i,
  output logic [N_CH-1:0]          wr_ready_o,
  output logic [N_PORT-1:0]        port_valid_o,
  output logic [N_PORT*ADDR_W-1:0] port_addr_o,
  output logic [N_PORT*DATA_W-1:0] port_data_o,
  output logic [CNT_W-1:0]         pend_cnt_o
);

  localparam int unsigned PTR_W = $clog2(N_CH);

  logic [N_CH-1:0]   pend_v_q, pend_v_d;
  logic [ADDR_W-1:0] pend_addr_q [N_CH];
  logic [ADDR_W-1:0] pend_addr_d [N_CH];
  logic [DATA_W-1:0] pend_data_q [N_CH];
  logic [DATA_W-1:0] pend_data_d [N_CH];
  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]  pend_cnt_q, pend_cnt_d;

  logic [N_CH-1:0]   grant;
  logic              any_grant;
  logic [PTR_W-1:0]  last_idx;
  int unsigned       rank [N_CH];
  logic              blocked;

  assign blocked = rst || flush_i;

  // Cyclic scan from rr_ptr; rank[i] is the port index assigned to channel i.
  always_comb begin
    int unsigned      base;
    int unsigned      n;
    logic [PTR_W-1:0] idx;
    grant     = '0;
    any_grant = 1'b0;
    last_idx  = rr_ptr_q;
    rank      = '{default: '0};
    base      = 32'(rr_ptr_q);
    n         = 0;
    idx       = '0;
    for (int unsigned j = 0; j < N_CH; j++) begin
      idx = PTR_W'((base + j) % N_CH);
      if (pend_v_q[idx] && (n < N_PORT)) begin
        grant[idx] = 1'b1;
        rank[idx]  = n;
        any_grant  = 1'b1;
        last_idx   = idx;
        n          = n + 1;
      end
    end
  end

  always_comb begin
    port_valid_o = '0;
    port_addr_o  = '0;
    port_data_o  = '0;
    for (int unsigned k = 0; k < N_PORT; k++) begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        if (!blocked && grant[i] && (rank[i] == k)) begin
          port_valid_o[k]                   = 1'b1;
          port_addr_o[k*ADDR_W +: ADDR_W]   = pend_addr_q[i];
          port_data_o[k*DATA_W +: DATA_W]   = pend_data_q[i];
        end
      end
    end
  end

  assign wr_ready_o = {N_CH{!blocked}} & (~pend_v_q | grant);
  assign pend_cnt_o = pend_cnt_q;

  always_comb begin
    pend_v_d    = pend_v_q;
    pend_addr_d = pend_addr_q;
    pend_data_d = pend_data_q;
    rr_ptr_d    = rr_ptr_q;
    pend_cnt_d  = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (wr_valid_i[i] && wr_ready_o[i]) begin
        pend_v_d[i]    = 1'b1;
        pend_addr_d[i] = wr_addr_i[i*ADDR_W +: ADDR_W];
        pend_data_d[i] = wr_data_i[i*DATA_W +: DATA_W];
      end else if (grant[i]) begin
        pend_v_d[i] = 1'b0;
      end
    end
    if (flush_i) begin
      pend_v_d = '0;
    end else if (any_grant) begin
      rr_ptr_d = (last_idx == PTR_W'(N_CH - 1)) ? '0 : last_idx + PTR_W'(1);
    end
    for (int unsigned i = 0; i < N_CH; i++) begin
      pend_cnt_d = pend_cnt_d + CNT_W'(pend_v_d[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_v_q   <= '0;
      rr_ptr_q   <= '0;
      pend_cnt_q <= '0;
      for (int unsigned i = 0; i < N_CH; i++) begin
        pend_addr_q[i] <= '0;
        pend_data_q[i] <= '0;
      end
    end else begin
      pend_v_q    <= pend_v_d;
      rr_ptr_q    <= rr_ptr_d;
      pend_cnt_q  <= pend_cnt_d;
      pend_addr_q <= pend_addr_d;
      pend_data_q <= pend_data_d;
    end
  end

endmodule

// File: tb/tb_prf_write_arbiter.sv
// Directed bench for prf_write_arbiter: per-cycle port/ready/count checks plus a
// scoreboard of accepted writebacks matched against regfile port writes.
module tb_prf_write_arbiter;

  localparam int NC = 6;
  localparam int NP = 2;
  localparam int AW = 6;
  localparam int DW = 64;
  localparam int CW = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush_i;
  logic [NC-1:0]     wr_valid_i;
  logic [NC*AW-1:0]  wr_addr_i;
  logic [NC*DW-1:0]  wr_data_i;
  logic [NC-1:0]     wr_ready_o;
  logic [NP-1:0]     port_valid_o;
  logic [NP*AW-1:0]  port_addr_o;
  logic [NP*DW-1:0]  port_data_o;
  logic [CW-1:0]     pend_cnt_o;

  logic [AW-1:0]     src_a [NC];
  logic [DW-1:0]     src_d [NC];
  logic [NC-1:0]     src_v;
  logic [NC-1:0]     stream;
  logic [NC-1:0]     acc;

  typedef struct {
    int unsigned   ch;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int unsigned   stamp;
  } ent_t;

  ent_t        sb[$];
  int unsigned cyc;
  int          n_chk;
  int          n_fail;

  always #5 clk = ~clk;

  prf_write_arbiter #(
    .N_CH   (NC),
    .N_PORT (NP),
    .ADDR_W (AW),
    .DATA_W (DW),
    .CNT_W  (CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (flush_i),
    .wr_valid_i   (wr_valid_i),
    .wr_addr_i    (wr_addr_i),
    .wr_data_i    (wr_data_i),
    .wr_ready_o   (wr_ready_o),
    .port_valid_o (port_valid_o),
    .port_addr_o  (port_addr_o),
    .port_data_o  (port_data_o),
    .pend_cnt_o   (pend_cnt_o)
  );

  always_comb begin
    wr_valid_i = src_v;
    wr_addr_i  = '0;
    wr_data_i  = '0;
    for (int i = 0; i < NC; i++) begin
      wr_addr_i[i*AW +: AW] = src_a[i];
      wr_data_i[i*DW +: DW] = src_d[i];
    end
  end

  // Retire port writes against the scoreboard, then record this cycle's accepts.
  always @(negedge clk) begin
    int            found;
    logic          in_order;
    logic [AW-1:0] pa;
    logic [DW-1:0] pd;
    cyc = cyc + 1;
    acc = '0;
    for (int k = 0; k < NP; k++) begin
      if (port_valid_o[k] === 1'b1) begin
        pa    = port_addr_o[k*AW +: AW];
        pd    = port_data_o[k*DW +: DW];
        found = -1;
        for (int j = 0; j < sb.size(); j++)
          if (found < 0 && sb[j].addr === pa && sb[j].data === pd) found = j;
        n_chk++;
        assert ((found >= 0) === 1'b1) else begin
          n_fail++;
          $error("FAIL sb_match port%0d: observed addr=%h data=%h, required a queued entry (%0d queued)",
                 k, pa, pd, sb.size());
        end
        if (found >= 0) begin
          in_order = 1'b1;
          for (int j = 0; j < found; j++)
            if (sb[j].ch == sb[found].ch) in_order = 1'b0;
          n_chk++;
          assert (in_order === 1'b1) else begin
            n_fail++;
            $error("FAIL sb_order ch%0d: observed out-of-order data=%h, required oldest first", sb[found].ch, pd);
          end
          n_chk++;
          assert ((cyc - sb[found].stamp <= 3) === 1'b1) else begin
            n_fail++;
            $error("FAIL sb_wait ch%0d: observed wait %0d cycles, required <= 3", sb[found].ch, cyc - sb[found].stamp);
          end
          sb.delete(found);
        end
      end
    end
    if (rst || flush_i) begin
      sb.delete();
    end else begin
      for (int i = 0; i < NC; i++) begin
        if (wr_valid_i[i] && wr_ready_o[i]) begin
          sb.push_back('{ch: i, addr: src_a[i], data: src_d[i], stamp: cyc});
          acc[i] = 1'b1;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h, required %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < NC; i++) begin
      if (acc[i]) begin
        if (stream[i]) src_d[i] = src_d[i] + 1;
        else           src_v[i] = 1'b0;
      end
    end
  endtask

  task automatic req(input int ch, input logic [AW-1:0] a, input logic [DW-1:0] d);
    src_v[ch] = 1'b1;
    src_a[ch] = a;
    src_d[ch] = d;
  endtask

  initial begin
    n_chk   = 0;
    n_fail  = 0;
    cyc     = 0;
    rst     = 1'b1;
    flush_i = 1'b0;
    src_v   = '0;
    stream  = '0;
    for (int i = 0; i < NC; i++) begin
      src_a[i] = '0;
      src_d[i] = '0;
    end

    // Reset, then idle
    tick();
    chk("rst_rdy", wr_ready_o, 0);
    chk("rst_pv", port_valid_o, 0);
    chk("rst_cnt", pend_cnt_o, 0);
    tick();
    chk("rst_rdy2", wr_ready_o, 0);
    chk("rst_pv2", port_valid_o, 0);
    rst = 1'b0;
    #1;
    chk("idle_rdy", wr_ready_o, 6'b111111);
    chk("idle_pv", port_valid_o, 0);
    chk("idle_cnt", pend_cnt_o, 0);

    // Single request on ch3
    req(3, 6'h15, 64'hDEAD);
    tick();
    chk("single_pv", port_valid_o, 2'b01);
    chk("single_addr", port_addr_o, {6'h00, 6'h15});
    chk("single_data", port_data_o, {64'h0, 64'hDEAD});
    chk("single_cnt", pend_cnt_o, 1);
    tick();
    chk("single_pv_t2", port_valid_o, 0);
    chk("single_cnt_t2", pend_cnt_o, 0);

    // rr_ptr is now 4: scan order 4,5,0,1,2,3 puts ch4 ahead of ch3
    req(3, 6'h21, 64'h3333);
    req(4, 6'h22, 64'h4444);
    tick();
    chk("ptr4_pv", port_valid_o, 2'b11);
    chk("ptr4_addr", port_addr_o, {6'h21, 6'h22});
    chk("ptr4_cnt", pend_cnt_o, 2);
    tick();

    // Address 0 on ch5 also moves rr_ptr to 0
    req(5, 6'h00, 64'h5555);
    tick();
    chk("addr0_pv", port_valid_o, 2'b01);
    chk("addr0_addr", port_addr_o, 0);
    chk("addr0_data", port_data_o, {64'h0, 64'h5555});
    tick();

    // Oversubscription from rr_ptr=0
    for (int i = 0; i < NC; i++) req(i, AW'(i + 1), 64'hA0 + DW'(i));
    tick();
    chk("over1_cnt", pend_cnt_o, 6);
    chk("over1_addr", port_addr_o, {6'd2, 6'd1});
    chk("over1_data", port_data_o, {64'hA1, 64'hA0});
    chk("over1_rdy", wr_ready_o, 6'b000011);
    tick();
    chk("over2_cnt", pend_cnt_o, 4);
    chk("over2_addr", port_addr_o, {6'd4, 6'd3});
    chk("over2_rdy", wr_ready_o, 6'b001111);
    tick();
    chk("over3_cnt", pend_cnt_o, 2);
    chk("over3_addr", port_addr_o, {6'd6, 6'd5});
    chk("over3_rdy", wr_ready_o, 6'b111111);
    tick();
    chk("over4_cnt", pend_cnt_o, 0);
    chk("over4_pv", port_valid_o, 0);

    // Move rr_ptr to 3, then ch0/ch1 stream while ch5 fires once
    req(2, 6'h30, 64'h2222);
    tick();
    chk("ptr3_pv", port_valid_o, 2'b01);
    tick();
    stream[0] = 1'b1;
    stream[1] = 1'b1;
    req(0, 6'h10, 64'h1000);
    req(1, 6'h11, 64'h1100);
    req(5, 6'h35, 64'h5005);
    tick();
    chk("starve_pv", port_valid_o, 2'b11);
    chk("starve_addr", port_addr_o, {6'h10, 6'h35});
    chk("starve_rdy", wr_ready_o, 6'b111101);
    for (int c = 0; c < 100; c++) begin
      tick();
      chk("starve_steady_pv", port_valid_o, 2'b11);
    end
    stream = '0;
    src_v  = '0;
    tick();
    chk("starve_drain_cnt", pend_cnt_o, 0);
    chk("starve_drain_pv", port_valid_o, 0);

    // Flush mid-drain with rr_ptr=3
    req(2, 6'h32, 64'h20002);
    tick();
    chk("fl_ptr_addr", port_addr_o, {6'h00, 6'h32});
    tick();
    for (int i = 0; i < 5; i++) req(i, 6'h20 + AW'(i), 64'hF0 + DW'(i));
    tick();
    chk("fl_cnt5", pend_cnt_o, 5);
    chk("fl_addr5", port_addr_o, {6'h24, 6'h23});
    flush_i = 1'b1;
    #1;
    chk("fl_pv", port_valid_o, 0);
    chk("fl_rdy", wr_ready_o, 0);
    tick();
    flush_i = 1'b0;
    #1;
    chk("fl_cnt0", pend_cnt_o, 0);
    chk("fl_pv_after", port_valid_o, 0);
    chk("fl_rdy_after", wr_ready_o, 6'b111111);
    req(2, 6'h3A, 64'hC2);
    req(3, 6'h3B, 64'hC3);
    tick();
    chk("fl_ptr_hold", port_addr_o, {6'h3A, 6'h3B});
    tick();

    // Reset together with flush clears rr_ptr
    for (int i = 0; i < 5; i++) req(i, 6'h28 + AW'(i), 64'hE0 + DW'(i));
    tick();
    chk("rf_cnt5", pend_cnt_o, 5);
    chk("rf_addr5", port_addr_o, {6'h2C, 6'h2B});
    rst     = 1'b1;
    flush_i = 1'b1;
    #1;
    chk("rf_pv", port_valid_o, 0);
    chk("rf_rdy", wr_ready_o, 0);
    tick();
    rst     = 1'b0;
    flush_i = 1'b0;
    #1;
    chk("rf_cnt0", pend_cnt_o, 0);
    chk("rf_pv_after", port_valid_o, 0);
    chk("rf_rdy_after", wr_ready_o, 6'b111111);
    req(2, 6'h3C, 64'hD2);
    req(3, 6'h3D, 64'hD3);
    tick();
    chk("rf_ptr0", port_addr_o, {6'h3D, 6'h3C});
    tick();

    // Back-to-back throughput on ch2
    stream[2] = 1'b1;
    req(2, 6'h12, 64'h100);
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("b2b_rdy", wr_ready_o[2], 1'b1);
      chk("b2b_pv", port_valid_o, 2'b01);
      chk("b2b_data", port_data_o, {64'h0, 64'h100 + DW'(k)});
    end
    stream = '0;
    src_v  = '0;
    tick();
    tick();
    chk("end_cnt", pend_cnt_o, 0);
    chk("end_sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
